// File: rtl/craps_round_ctrl.sv
// Craps round sequencer: roll-button edge to dice request, dice validation, come-out/point resolution.
// Optional win/loss tally counters are built when CRAPS_STATS_EN is defined.
module craps_round_ctrl #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TMO_CYC = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             roll_i,
  input  logic [2:0]       die_a_i,
  input  logic [2:0]       die_b_i,
  input  logic             dice_valid_i,
  output logic             dice_req_o,
  output logic [3:0]       sum_o,
  output logic [3:0]       point_o,
  output logic [1:0]       phase_o,
  output logic             busy_o
`ifdef CRAPS_STATS_EN
  ,
  output logic [CNT_W-1:0] win_cnt_o,
  output logic [CNT_W-1:0] loss_cnt_o
`endif
);

  localparam int unsigned TMR_W = 8;
  localparam int unsigned SUM_W = 4;

  typedef enum logic [2:0] {
    CO_IDLE,
    CO_WAIT,
    PT_IDLE,
    PT_WAIT,
    WIN,
    LOSE
  } state_e;

  state_e             state_q, state_d;
  logic               roll_q;
  logic               dice_req_q, dice_req_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [SUM_W-1:0]   point_q, point_d;
  logic [1:0]         phase_q, phase_d;
  logic               busy_q, busy_d;
  logic [TMR_W-1:0]   timer_q, timer_d;

  logic               roll_edge_c;
  logic               dice_ok_c;
  logic [SUM_W-1:0]   roll_sum_c;

  assign roll_edge_c = roll_i & ~roll_q;
  assign dice_ok_c   = (die_a_i != 3'd0) && (die_a_i != 3'd7) &&
                       (die_b_i != 3'd0) && (die_b_i != 3'd7);
  assign roll_sum_c  = SUM_W'(die_a_i) + SUM_W'(die_b_i);

  // Next-state, roll resolution and request generation
  always_comb begin
    state_d    = state_q;
    dice_req_d = 1'b0;
    sum_d      = sum_q;
    point_d    = point_q;
    timer_d    = timer_q;
    phase_d    = 2'b00;
    busy_d     = 1'b0;

    unique case (state_q)
      CO_IDLE: begin
        if (roll_edge_c) begin
          state_d    = CO_WAIT;
          dice_req_d = 1'b1;
          timer_d    = '0;
        end
      end
      WIN, LOSE: begin
        if (roll_edge_c) begin
          state_d    = CO_WAIT;
          dice_req_d = 1'b1;
          timer_d    = '0;
          point_d    = '0;
        end
      end
      PT_IDLE: begin
        if (roll_edge_c) begin
          state_d    = PT_WAIT;
          dice_req_d = 1'b1;
          timer_d    = '0;
        end
      end
      CO_WAIT, PT_WAIT: begin
        if (dice_valid_i) begin
          if (!dice_ok_c) begin
            // Back-to-back requests are suppressed; the timeout re-requests instead
            dice_req_d = ~dice_req_q;
            timer_d    = '0;
          end else begin
            sum_d = roll_sum_c;
            if (state_q == CO_WAIT) begin
              unique case (roll_sum_c)
                4'd7, 4'd11:        state_d = WIN;
                4'd2, 4'd3, 4'd12:  state_d = LOSE;
                default: begin
                  point_d = roll_sum_c;
                  state_d = PT_IDLE;
                end
              endcase
            end else if (roll_sum_c == point_q) begin
              state_d = WIN;
            end else if (roll_sum_c == 4'd7) begin
              state_d = LOSE;
            end else begin
              state_d = PT_IDLE;
            end
          end
        end else if (timer_q == TMR_W'(TMO_CYC)) begin
          dice_req_d = 1'b1;
          timer_d    = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = CO_IDLE;
    endcase

    unique case (state_d)
      PT_IDLE:  phase_d = 2'b01;
      PT_WAIT: begin
        phase_d = 2'b01;
        busy_d  = 1'b1;
      end
      CO_WAIT:  busy_d  = 1'b1;
      WIN:      phase_d = 2'b10;
      LOSE:     phase_d = 2'b11;
      default:  phase_d = 2'b00;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= CO_IDLE;
      roll_q     <= 1'b0;
      dice_req_q <= 1'b0;
      sum_q      <= '0;
      point_q    <= '0;
      phase_q    <= 2'b00;
      busy_q     <= 1'b0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      roll_q     <= roll_i;
      dice_req_q <= dice_req_d;
      sum_q      <= sum_d;
      point_q    <= point_d;
      phase_q    <= phase_d;
      busy_q     <= busy_d;
      timer_q    <= timer_d;
    end
  end

  assign dice_req_o = dice_req_q;
  assign sum_o      = sum_q;
  assign point_o    = point_q;
  assign phase_o    = phase_q;
  assign busy_o     = busy_q;

`ifdef CRAPS_STATS_EN
  logic [CNT_W-1:0] win_cnt_q;
  logic [CNT_W-1:0] loss_cnt_q;
  logic             win_evt_c;
  logic             loss_evt_c;

  assign win_evt_c  = (state_d == WIN)  && (state_q != WIN);
  assign loss_evt_c = (state_d == LOSE) && (state_q != LOSE);

  // Saturating game tallies
  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt_q  <= '0;
      loss_cnt_q <= '0;
    end else begin
      if (win_evt_c && (win_cnt_q != {CNT_W{1'b1}})) begin
        win_cnt_q <= win_cnt_q + CNT_W'(1);
      end
      if (loss_evt_c && (loss_cnt_q != {CNT_W{1'b1}})) begin
        loss_cnt_q <= loss_cnt_q + CNT_W'(1);
      end
    end
  end

  assign win_cnt_o  = win_cnt_q;
  assign loss_cnt_o = loss_cnt_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^(32'(CNT_W));
`endif

endmodule

// File: tb/tb_craps_round_ctrl.sv
// Bench for craps_round_ctrl: directed roll table, timeout/reject/reset sequences,
// and random games checked against a rule-level game model.
module tb_craps_round_ctrl;

  localparam int unsigned CNT_W   = 2;
  localparam int unsigned TMO_CYC = 15;
  localparam int          CMAX    = (1 << CNT_W) - 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       roll_i;
  logic [2:0] die_a_i, die_b_i;
  logic       dice_valid_i;
  logic       dice_req_o;
  logic [3:0] sum_o, point_o;
  logic [1:0] phase_o;
  logic       busy_o;
`ifdef CRAPS_STATS_EN
  logic [CNT_W-1:0] win_cnt_o, loss_cnt_o;
`endif

  craps_round_ctrl #(.CNT_W(CNT_W), .TMO_CYC(TMO_CYC)) dut (
    .clk          (clk),
    .reset        (reset),
    .roll_i       (roll_i),
    .die_a_i      (die_a_i),
    .die_b_i      (die_b_i),
    .dice_valid_i (dice_valid_i),
    .dice_req_o   (dice_req_o),
    .sum_o        (sum_o),
    .point_o      (point_o),
    .phase_o      (phase_o),
    .busy_o       (busy_o)
`ifdef CRAPS_STATS_EN
    ,
    .win_cnt_o    (win_cnt_o),
    .loss_cnt_o   (loss_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Game model: phase 0 come-out, 1 point, 2 won, 3 lost
  int m_phase, m_point, m_sum, m_wins, m_losses;

  typedef struct {
    int a;
    int b;
    int exp_sum;
    int exp_point;
    int exp_phase;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_point = 0; m_sum = 0; m_wins = 0; m_losses = 0;
  endtask

  task automatic model_start();
    if (m_phase >= 2) begin
      m_phase = 0;
      m_point = 0;
    end
  endtask

  task automatic model_win();
    m_phase = 2;
    if (m_wins < CMAX) m_wins++;
  endtask

  task automatic model_lose();
    m_phase = 3;
    if (m_losses < CMAX) m_losses++;
  endtask

  task automatic model_resolve(input int a, input int b);
    int s;
    s = a + b;
    m_sum = s;
    if (m_phase == 0) begin
      if (s == 7 || s == 11) model_win();
      else if (s == 2 || s == 3 || s == 12) model_lose();
      else begin
        m_point = s;
        m_phase = 1;
      end
    end else begin
      if (s == m_point) model_win();
      else if (s == 7) model_lose();
    end
  endtask

  task automatic check_outs(input string tag, input int exp_busy);
    check({tag, ".sum"},   int'(sum_o),   m_sum);
    check({tag, ".point"}, int'(point_o), m_point);
    check({tag, ".phase"}, int'(phase_o), m_phase);
    check({tag, ".busy"},  int'(busy_o),  exp_busy);
`ifdef CRAPS_STATS_EN
    check({tag, ".wins"},  int'(win_cnt_o),  m_wins);
    check({tag, ".losses"}, int'(loss_cnt_o), m_losses);
`endif
  endtask

  task automatic start_roll(input string tag);
    roll_i = 1'b1;
    tick();
    model_start();
    check({tag, ".req_pulse"}, int'(dice_req_o), 1);
    check_outs({tag, ".start"}, 1);
    roll_i = 1'b0;
  endtask

  task automatic give_dice(input string tag, input int a, input int b, input int lat);
    bit ok;
    ok = (a >= 1 && a <= 6 && b >= 1 && b <= 6);
    for (int i = 0; i < lat; i++) begin
      tick();
      if (i == 0) check({tag, ".req_single"}, int'(dice_req_o), 0);
    end
    die_a_i = 3'(a);
    die_b_i = 3'(b);
    dice_valid_i = 1'b1;
    tick();
    dice_valid_i = 1'b0;
    die_a_i = 3'($urandom_range(0, 7));
    die_b_i = 3'($urandom_range(0, 7));
    if (ok) begin
      model_resolve(a, b);
      check({tag, ".req_idle"}, int'(dice_req_o), 0);
      check_outs({tag, ".resolve"}, 0);
    end else begin
      check({tag, ".req_retry"}, int'(dice_req_o), 1);
      check_outs({tag, ".reject"}, 1);
    end
  endtask

  initial begin
    vecs[0]  = '{3, 4,  7,  0, 2};
    vecs[1]  = '{1, 1,  2,  0, 3};
    vecs[2]  = '{2, 4,  6,  6, 1};
    vecs[3]  = '{5, 3,  8,  6, 1};
    vecs[4]  = '{1, 5,  6,  6, 2};
    vecs[5]  = '{1, 3,  4,  4, 1};
    vecs[6]  = '{3, 4,  7,  4, 3};
    vecs[7]  = '{6, 5, 11,  0, 2};
    vecs[8]  = '{6, 6, 12,  0, 3};
    vecs[9]  = '{4, 6, 10, 10, 1};
    vecs[10] = '{2, 2,  4, 10, 1};
    vecs[11] = '{3, 4,  7, 10, 3};

    reset = 1'b1; roll_i = 1'b0; dice_valid_i = 1'b0;
    die_a_i = 3'd0; die_b_i = 3'd0;
    model_reset();
    tick(); tick();
    reset = 1'b0;
    check("reset.req", int'(dice_req_o), 0);
    check_outs("reset", 0);

    // Directed roll table
    for (int i = 0; i < 12; i++) begin
      start_roll($sformatf("vec%0d", i));
      give_dice($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, 1 + (i % 3));
      check($sformatf("vec%0d.tbl_sum", i),   int'(sum_o),   vecs[i].exp_sum);
      check($sformatf("vec%0d.tbl_point", i), int'(point_o), vecs[i].exp_point);
      check($sformatf("vec%0d.tbl_phase", i), int'(phase_o), vecs[i].exp_phase);
    end

    // Illegal dice are rejected and re-requested
    start_roll("rej");
    give_dice("rej0", 0, 5, 2);
    give_dice("rej1", 4, 7, 1);
    give_dice("rej2", 3, 3, 2);

    // Timeout re-request with ignored roll edges during the wait
    start_roll("tmo");
    for (int i = 1; i <= int'(TMO_CYC); i++) begin
      roll_i = 1'(i % 2);
      tick();
      check($sformatf("tmo.quiet%0d", i), int'(dice_req_o), 0);
      check($sformatf("tmo.busy%0d", i),  int'(busy_o), 1);
    end
    roll_i = 1'b0;
    tick();
    check("tmo.rereq", int'(dice_req_o), 1);
    check_outs("tmo.hold", 1);
    give_dice("tmo", 5, 5, 2);

    // Roll edge coinciding with dice_valid is ignored
    if (m_phase != 1) begin
      start_roll("pre_co");
      give_dice("pre_co", 2, 2, 1);
      while (m_phase != 1) begin
        start_roll("pre_co2");
        give_dice("pre_co2", 4, 1, 1);
      end
    end
    start_roll("coin");
    tick();
    roll_i = 1'b1;
    die_a_i = 3'd1; die_b_i = 3'd1;
    dice_valid_i = 1'b1;
    tick();
    dice_valid_i = 1'b0;
    roll_i = 1'b0;
    model_resolve(1, 1);
    tick();
    check("coin.no_req", int'(dice_req_o), 0);
    check_outs("coin", 0);

    // Reset in PT_WAIT together with a valid roll
    start_roll("rst_pt");
    tick();
    reset = 1'b1;
    die_a_i = 3'd3; die_b_i = 3'd3;
    dice_valid_i = 1'b1;
    tick();
    reset = 1'b0;
    dice_valid_i = 1'b0;
    model_reset();
    check("rst_pt.req", int'(dice_req_o), 0);
    check_outs("rst_pt", 0);

    // Random games against the model
    for (int r = 0; r < 150; r++) begin
      int a, b;
      bit ok;
      start_roll($sformatf("rnd%0d", r));
      do begin
        a = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 7)
                                        : int'($urandom_range(1, 6));
        b = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 7)
                                        : int'($urandom_range(1, 6));
        ok = (a >= 1 && a <= 6 && b >= 1 && b <= 6);
        give_dice($sformatf("rnd%0d", r), a, b, int'($urandom_range(1, 5)));
      end while (!ok);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/craps_round_ctrl.md
# craps_round_ctrl

Sequencer for one player's craps game. It turns the player's roll button into roll requests to the dice generator and validates the returned dice. It holds the come-out/point phase, latches the point, and reports each roll's outcome to the display logic. It sits between the button debouncer, the dice generator and the seven-segment/LED outputs.

## Interface
Parameters:
- CNT_W, 8, width of win/loss tally counters
- TMO_CYC, 15, cycles to wait for dice_valid before re-requesting (1..255)

Ports:
- clk  in  1  system clock; all logic rising-edge
- reset  in  1  reset, synchronous, active-high
- roll  in  1  debounced roll button, level; rising edge detected internally
- die_a  in  3  first die value, legal 1..6
- die_b  in  3  second die value, legal 1..6
- dice_valid  in  1  one-cycle pulse; die_a/die_b valid this cycle
- dice_req  out  1  one-cycle pulse requesting a new roll
- sum  out  4  registered die_a+die_b of last accepted roll
- point  out  4  latched point; 0 when no point established
- phase  out  2  00 come-out, 01 point, 10 win, 11 lose
- busy  out  1  high while waiting for dice
- win_cnt  out  CNT_W  games won (CRAPS_STATS_EN only)
- loss_cnt  out  CNT_W  games lost (CRAPS_STATS_EN only)

## Operation
- Internal states:
  - CO_IDLE, CO_WAIT: come-out
  - PT_IDLE, PT_WAIT: point
  - WIN, LOSE
- phase encoding:
  - 00 in CO_*
  - 01 in PT_*
  - 10 in WIN
  - 11 in LOSE
- Roll edge: roll_q registered; edge = roll & ~roll_q.
- Edge acceptance:
  - Edge in CO_IDLE, WIN or LOSE: go to CO_WAIT, pulse dice_req.
  - Entry from WIN/LOSE clears point to 0.
  - Edge in PT_IDLE: go to PT_WAIT, pulse dice_req.
  - Edges in *_WAIT are ignored and not queued.
- Dice check in *_WAIT on dice_valid:
  - Either die 0 or 7: roll rejected; sum/point/phase unchanged; dice_req re-pulsed next cycle; timer restarts.
  - Otherwise sum = die_a + die_b (4-bit, 2..12), registered.
- Come-out resolution (CO_WAIT):
  - sum 7 or 11 → WIN
  - sum 2, 3 or 12 → LOSE
  - else point ← sum → PT_IDLE
- Point resolution (PT_WAIT):
  - sum == point → WIN
  - sum 7 → LOSE
  - else → PT_IDLE, point held
- Timeout: 8-bit timer runs in *_WAIT. When it reaches TMO_CYC with no dice_valid: re-pulse dice_req, clear timer, stay in state.
- dice_valid outside *_WAIT is ignored.
- busy = 1 exactly in CO_WAIT/PT_WAIT.

## Timing
- Reset values:
  - state CO_IDLE, phase 00
  - dice_req 0, sum 0, point 0, busy 0
  - win_cnt/loss_cnt 0
  - roll_q 0, timer 0
- Reset mid-wait: returns to CO_IDLE; a dice_valid that cycle is dropped.
- roll rising at cycle N (sampled) → dice_req high at N+1 for exactly 1 cycle, busy high from N+1.
- dice_valid at cycle M → sum, point, phase, state and counters updated at M+1; busy low at M+1 if resolved.
- Roll edge coinciding with dice_valid in *_WAIT: edge ignored, roll resolved normally.
- dice_req never high two consecutive cycles.
- Timeout re-request occurs TMO_CYC+1 cycles after the previous dice_req.

## Configuration
- CRAPS_STATS_EN defined:
  - win_cnt increments on every transition into WIN.
  - loss_cnt increments on every transition into LOSE.
  - Both saturate at 2^CNT_W−1.
  - Both are cleared only by reset.
- Not defined: win_cnt/loss_cnt ports absent; no counter logic.

## Test plan
- Reset, roll edge, dice 3+4 → dice_req one pulse at N+1; one cycle after dice_valid: sum 7, phase 10, point 0, win_cnt 1.
- Come-out 1+1 → phase 11, loss_cnt 1; next edge → phase 00, dice_req pulses, point cleared.
- Come-out 2+4 → point 6, phase 01; then 5+3 → phase 01, point 6; then 1+5 → phase 10.
- Point 4 established, then 3+4 → phase 11, point still 4 until next edge; next edge → point 0.
- Dice 0+5 returned → no state change, dice_req repulsed next cycle. Then no dice_valid for TMO_CYC cycles → dice_req repulsed; roll edges during wait are ignored.
- Reset asserted in PT_WAIT together with dice_valid 3+3 → all outputs at reset values next cycle. With CRAPS_STATS_EN and CNT_W=2: 4 wins → win_cnt stays 3.
